// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu_pkg;

  // Width of one ALU slice.
  localparam int NIB_W = 4;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ALU function selects used by the datapath controller.
  localparam logic [3:0] OP_ADD = 4'b1001;  // M=0: A plus B plus Cin
  localparam logic [3:0] OP_DBL = 4'b1100;  // M=0: A plus A plus Cin
  localparam logic [3:0] OP_NOT = 4'b0000;  // M=1: not A

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/result bus between the datapath controller and the nibble sequencer.
interface alu_nibble_sequencer_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_sel;
  logic             op_mode;
  logic             op_cin;
  logic [WIDTH-1:0] res;
  logic             res_cout;
  logic             res_zero;
  logic             res_valid;
  logic             res_ready;

  // Controller side: issues requests, consumes results.
  modport master (
    output start, op_a, op_b, op_sel, op_mode, op_cin, res_ready,
    input  ready, res, res_cout, res_zero, res_valid
  );

  // Sequencer side.
  modport slave (
    input  start, op_a, op_b, op_sel, op_mode, op_cin, res_ready,
    output ready, res, res_cout, res_zero, res_valid
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs a WIDTH-bit operation through an external 4-bit combinational ALU,
// one nibble per clock, LSB nibble first, rippling the carry between slices.
// WIDTH must be a multiple of 4 and at least 8.
module alu_nibble_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_nibble_sequencer_if.slave  bus,
  output logic [NIB_W-1:0]       alu_a,
  output logic [NIB_W-1:0]       alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_cin,
  input  logic [NIB_W-1:0]       alu_f,
  input  logic                   alu_cout
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       sel_q;
  logic             mode_q;
  logic             cin_q;
  logic             carry_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic             res_cout_q;
  logic             res_zero_q;

  logic [NIB_W-1:0] a_nib [NIB];
  logic [NIB_W-1:0] b_nib [NIB];

  // Slice the latched operands so the active nibble is a plain array lookup.
  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_q[gi*NIB_W +: NIB_W];
      assign b_nib[gi] = b_q[gi*NIB_W +: NIB_W];
    end
  endgenerate

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start)     state_next = RUN;
      RUN:     if (idx == LAST)   state_next = DONE;
      DONE:    if (bus.res_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // ALU drive: only live during RUN. In logic mode the slices are independent,
  // so the inter-slice carry is forced low whatever Cout the ALU reported.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_s   = '0;
    alu_m   = 1'b0;
    alu_cin = 1'b0;
    if (state == RUN) begin
      alu_a = a_nib[idx];
      alu_b = b_nib[idx];
      alu_s = sel_q;
      alu_m = mode_q;
      if (idx == '0)
        alu_cin = cin_q;
      else
        alu_cin = mode_q ? 1'b0 : carry_q;
    end
  end

  // Result with the current ALU nibble merged into slot idx.
  always_comb begin
    res_next = res_q;
    for (int i = 0; i < NIB; i++) begin
      if (IDX_W'(i) == idx)
        res_next[i*NIB_W +: NIB_W] = alu_f;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Operand latch, nibble counter, carry chain and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      mode_q     <= 1'b0;
      cin_q      <= 1'b0;
      carry_q    <= 1'b0;
      res_q      <= '0;
      res_cout_q <= 1'b0;
      res_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            sel_q   <= bus.op_sel;
            mode_q  <= bus.op_mode;
            cin_q   <= bus.op_cin;
            carry_q <= 1'b0;
            idx     <= '0;
            res_q   <= '0;
          end
        end
        RUN: begin
          res_q   <= res_next;
          carry_q <= alu_cout;
          if (idx == LAST) begin
            // Flags are frozen here so they stay stable through DONE and after.
            res_cout_q <= mode_q ? 1'b0 : alu_cout;
            res_zero_q <= (res_next == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.res       = res_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench: sequencer plus a behavioural 4-bit ALU slice, with a
// scoreboard of expected results pushed at acceptance and popped at res_valid.
module tb_alu_nibble_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_s, alu_f;
  logic       alu_m, alu_cin, alu_cout;
  logic [4:0] alu_sum;

  alu_nibble_sequencer_if #(.WIDTH(16)) bus ();

  alu_nibble_sequencer #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_s    (alu_s),
    .alu_m    (alu_m),
    .alu_cin  (alu_cin),
    .alu_f    (alu_f),
    .alu_cout (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit ALU slice. In logic mode Cout is meaningless, so it is driven high
  // to make sure the sequencer does not forward it into the next slice.
  always_comb begin
    alu_sum  = 5'd0;
    alu_f    = 4'd0;
    alu_cout = 1'b0;
    if (alu_m) begin
      case (alu_s)
        4'b0000: alu_f = ~alu_a;
        default: alu_f = alu_a ^ alu_b;
      endcase
      alu_cout = 1'b1;
    end else begin
      case (alu_s)
        4'b1001: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
        4'b1100: alu_sum = {1'b0, alu_a} + {1'b0, alu_a} + {4'd0, alu_cin};
        default: alu_sum = {1'b0, alu_a} + {4'd0, alu_cin};
      endcase
      alu_f    = alu_sum[3:0];
      alu_cout = alu_sum[4];
    end
  end

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic cin_log [0:3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Issue one op, check nibble drive and latency, compare against the
  // scoreboard, optionally stall the consumer, then hand the result back.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                        input logic mode, input logic cin, input logic [15:0] er,
                        input logic ec, input int hold);
    int   cnt;
    exp_t e;
    @(negedge clk);
    check("ready_idle", bus.ready, 1);
    bus.op_a    = a;
    bus.op_b    = b;
    bus.op_sel  = sel;
    bus.op_mode = mode;
    bus.op_cin  = cin;
    bus.start   = 1'b1;
    sb.push_back('{res: er, cout: ec, zero: (er == 16'h0)});
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.op_a   = 16'($urandom);
    bus.op_b   = 16'($urandom);
    bus.op_cin = ~cin;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      if (bus.res_valid) break;
      if (cnt < 4) begin
        check("alu_a_nib", alu_a, a[4*cnt +: 4]);
        check("alu_b_nib", alu_b, b[4*cnt +: 4]);
        cin_log[cnt] = alu_cin;
      end
      cnt++;
    end
    check("latency", cnt, 4);
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("res", bus.res, e.res);
      check("res_cout", bus.res_cout, e.cout);
      check("res_zero", bus.res_zero, e.zero);
    end
    for (int h = 0; h < hold; h++) begin
      bus.start = (h == 1);
      @(negedge clk);
      check("hold_res", bus.res, er);
      check("hold_ready", bus.ready, 0);
      check("hold_valid", bus.res_valid, 1);
    end
    bus.start     = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("back_ready", bus.ready, 1);
    check("back_valid", bus.res_valid, 0);
    check("kept_res", bus.res, er);
    $display("op a=%h b=%h s=%b m=%b cin=%b -> res=%h cout=%b", a, b, sel, mode, cin, bus.res, bus.res_cout);
  endtask

  initial begin
    logic [16:0] sum;
    logic [15:0] ra, rb;
    logic [3:0]  rs;
    logic        rc;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sel    = '0;
    bus.op_mode   = 1'b0;
    bus.op_cin    = 1'b0;
    bus.res_ready = 1'b0;
    #12;
    check("rst_ready", bus.ready, 1);
    check("rst_valid", bus.res_valid, 0);
    check("rst_res", bus.res, 0);
    check("rst_cout", bus.res_cout, 0);
    check("rst_zero", bus.res_zero, 0);
    check("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0FCD, OP_ADD, 1'b0, 1'b0, 16'h2201, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
    run_op(16'h8421, 16'h0000, OP_DBL, 1'b0, 1'b1, 16'h0843, 1'b1, 0);

    run_op(16'hA5F0, 16'h0000, OP_NOT, 1'b1, 1'b1, 16'h5A0F, 1'b0, 0);
    check("not_cin0", cin_log[0], 1);
    check("not_cin1", cin_log[1], 0);
    check("not_cin2", cin_log[2], 0);
    check("not_cin3", cin_log[3], 0);

    // Consumer stall with start pulsed while DONE.
    run_op(16'h1111, 16'h2222, OP_ADD, 1'b0, 1'b0, 16'h3333, 1'b0, 5);

    // Abort mid-RUN: reset must take effect without a clock edge.
    @(negedge clk);
    bus.op_a    = 16'h7777;
    bus.op_b    = 16'h1111;
    bus.op_sel  = OP_ADD;
    bus.op_mode = 1'b0;
    bus.op_cin  = 1'b0;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", bus.ready, 1);
    check("abort_valid", bus.res_valid, 0);
    check("abort_res", bus.res, 0);
    check("abort_alu", {alu_a, alu_b, alu_s, alu_m, alu_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("abort mid-RUN -> ready=%b res=%h", bus.ready, bus.res);
    run_op(16'h0001, 16'h0001, OP_ADD, 1'b0, 1'b0, 16'h0002, 1'b0, 0);

    // Random full-width adds/doubles against a 17-bit reference sum.
    for (int k = 0; k < 8; k++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rs  = ($urandom_range(0, 1) == 0) ? OP_ADD : OP_DBL;
      rc  = 1'($urandom_range(0, 1));
      sum = {1'b0, ra} + {1'b0, (rs == OP_DBL) ? ra : rb} + {16'd0, rc};
      run_op(ra, rb, rs, 1'b0, rc, sum[15:0], sum[16], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
